conv_layer_ctrl: RTL
====================

CONV_LAYER_CTRL -- requirements
Module: conv_layer_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- MAPSIZE, 32, input map edge length.
- KSIZE, 5, kernel edge length, 1..MAPSIZE.
- STRIDE, 1, window step in x and y, at least 1.
- CHANNELS, 1, input channels summed per output.
- DATA_W, 8, signed feature/weight width.
- ACC_W, 32, signed accumulator/output width.
REQ-002 Derived OUTSIZE = (MAPSIZE-KSIZE)/STRIDE + 1 (integer division).
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, reset, synchronous, active-high.
- start, in, 1, launch one full layer pass.
- feature, in, [CHANNELS][MAPSIZE][MAPSIZE] x DATA_W signed, held stable while busy.
- weights, in, [CHANNELS][KSIZE][KSIZE] x DATA_W signed, held stable while busy.
- bias, in, ACC_W signed, added once per output.
- relu_en, in, 1, clamp negative results to 0; sampled at start.
- out_ready, in, 1, downstream accepts out_data.
- out_valid, out, 1, out_data/out_row/out_col are valid.
- out_data, out, ACC_W signed, one output pixel.
- out_row, out, clog2(OUTSIZE) bits (min 1), output row index.
- out_col, out, same width, output column index.
- busy, out, 1, pass in progress.
- done, out, 1, pass complete; held until next start or rst.

Function
REQ-004 States: IDLE, ISSUE, WAIT, EMIT, DONE.
REQ-005 IDLE/DONE, start=1: clear row, col, ch to 0; load acc = bias; latch relu_en; go to ISSUE.
REQ-006 ISSUE: pulse engine start for window origin (row*STRIDE, col*STRIDE), channel ch; go to WAIT.
REQ-007 WAIT: on engine done, acc += engine result. If ch == CHANNELS-1, go to EMIT; otherwise ch++ and go to ISSUE.
REQ-008 EMIT: out_valid = 1; out_data = (relu && acc<0) ? 0 : acc.
REQ-009 Output transfer occurs when out_valid && out_ready. Outputs are raster order, col fastest.
REQ-010 On transfer: if (row,col) == (OUTSIZE-1,OUTSIZE-1), go to DONE. Otherwise advance col (wrap to 0 and increment row), set ch=0, acc=bias, go to ISSUE.
REQ-011 Backpressure: while out_valid && !out_ready, out_valid, out_data, out_row and out_col stay stable; out_valid never drops without a transfer.
REQ-012 start is ignored while busy (ISSUE/WAIT/EMIT).
REQ-013 busy = 1 in ISSUE, WAIT and EMIT only. done = 1 in DONE only.
REQ-014 Latency: first out_valid rises 2*CHANNELS+1 cycles after start is sampled. Each further output takes 2*CHANNELS cycles after the previous transfer.
REQ-015 Arithmetic: products are DATA_W x DATA_W signed, summed sign-extended to ACC_W. Overflow wraps two's-complement; no saturation.
REQ-016 KSIZE == MAPSIZE gives exactly one output at (0,0). Any window touching an index >= MAPSIZE is never issued.

Reset
REQ-017 rst=1 at any clock edge, including mid-pass, forces IDLE. It clears row, col, ch, acc and the latched relu_en. The outputs reset to out_valid=0, out_data=0, out_row=0, out_col=0, busy=0, done=0.
REQ-018 No pending output survives reset; the next start begins at (0,0).

Structure
REQ-019 Package conv_pkg holds the state enum type and a function computing OUTSIZE from MAPSIZE, KSIZE and STRIDE.
REQ-020 Sub-module conv_window_mac holds the KSIZE x KSIZE signed dot product. It has start/done handshake, registered result and exactly 1-cycle latency. The window mux and accumulator stay in conv_layer_ctrl.

Verification
REQ-021 The bench covers these directed scenarios:
- MAPSIZE=8, KSIZE=3, STRIDE=1, CHANNELS=1, all-ones data, bias=0, out_ready=1 -> 36 outputs, each 9, raster order, then done=1.
- Same with STRIDE=2 -> 9 outputs, indices (0,0)..(2,2); first window origin (0,0), last (4,4).
- CHANNELS=2, all ones, bias=5 -> every out_data = 23; first out_valid 5 cycles after start.
- Feature all -1, weights 1, CHANNELS=1, KSIZE=3 -> out_data = -9 with relu_en=0, and 0 with relu_en=1.
- out_ready held low 5 cycles in EMIT -> out_valid stays 1 and data/indices are unchanged; one transfer on release.
- rst asserted at output 10, then start -> all outputs 0 with busy=0, then a full 36-output pass restarting at (0,0); a start during busy has no effect.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and output-size helper for the convolution controller
package conv_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DONE} state_e;
  function automatic int out_size(input int mapsize, input int ksize, input int stride);
    return (mapsize - ksize) / stride + 1;
  endfunction
endpackage

// File: rtl/conv_window_mac.sv
// conv_window_mac: KSIZE x KSIZE signed dot product with a registered result one cycle after start
module conv_window_mac #(
  parameter int KSIZE = 5,
  parameter int DATA_W = 8,
  parameter int ACC_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] win,
  input  logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] wgt,
  output logic done,
  output logic signed [ACC_W-1:0] result
);
  genvar i, j;
  logic signed [2*DATA_W-1:0] prod [KSIZE][KSIZE];
  logic signed [ACC_W-1:0] sum, result_d, result_q;
  logic done_d, done_q;
  for (i = 0; i < KSIZE; i++) begin : g_r
    for (j = 0; j < KSIZE; j++) begin : g_c
      assign prod[i][j] = $signed(win[i][j]) * $signed(wgt[i][j]);
    end
  end
  always_comb begin
    sum = '0;
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        sum = sum + ACC_W'(prod[r][c]);
    result_d = start ? sum : result_q;
    done_d = start;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      done_q <= 1'b0;
    end else begin
      result_q <= result_d;
      done_q <= done_d;
    end
  end
  assign done = done_q;
  assign result = result_q;
endmodule

// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl: walks output windows in raster order, accumulates per-channel MAC results and streams pixels with backpressure
module conv_layer_ctrl import conv_pkg::*; #(
  parameter int MAPSIZE = 32,
  parameter int KSIZE = 5,
  parameter int STRIDE = 1,
  parameter int CHANNELS = 1,
  parameter int DATA_W = 8,
  parameter int ACC_W = 32,
  localparam int OUTSIZE = out_size(MAPSIZE, KSIZE, STRIDE),
  localparam int OW = OUTSIZE > 1 ? $clog2(OUTSIZE) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [CHANNELS-1:0][MAPSIZE-1:0][MAPSIZE-1:0][DATA_W-1:0] feature,
  input  logic [CHANNELS-1:0][KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] weights,
  input  logic signed [ACC_W-1:0] bias,
  input  logic relu_en,
  input  logic out_ready,
  output logic out_valid,
  output logic signed [ACC_W-1:0] out_data,
  output logic [OW-1:0] out_row,
  output logic [OW-1:0] out_col,
  output logic busy,
  output logic done
);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int RW = MAPSIZE > 1 ? $clog2(MAPSIZE) : 1;
  state_e state_d, state_q;
  logic [OW-1:0] row_d, row_q, col_d, col_q;
  logic [CW-1:0] ch_d, ch_q;
  logic signed [ACC_W-1:0] acc_d, acc_q, mac_result;
  logic relu_d, relu_q, mac_start, mac_done, last_col, last_px;
  logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] win;
  always_comb begin
    win = '0;
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        win[r][c] = feature[ch_q][RW'(int'(row_q) * STRIDE + r)][RW'(int'(col_q) * STRIDE + c)];
  end
  conv_window_mac #(.KSIZE(KSIZE), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk),
    .rst(rst),
    .start(mac_start),
    .win(win),
    .wgt(weights[ch_q]),
    .done(mac_done),
    .result(mac_result)
  );
  assign last_col = col_q == OW'(OUTSIZE - 1);
  assign last_px = last_col && row_q == OW'(OUTSIZE - 1);
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    ch_d = ch_q;
    acc_d = acc_q;
    relu_d = relu_q;
    mac_start = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        row_d = '0;
        col_d = '0;
        ch_d = '0;
        acc_d = bias;
        relu_d = relu_en;
        state_d = ISSUE;
      end
      ISSUE: begin
        mac_start = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (mac_done) begin
        acc_d = acc_q + mac_result;
        ch_d = ch_q == CW'(CHANNELS - 1) ? ch_q : ch_q + 1'b1;
        state_d = ch_q == CW'(CHANNELS - 1) ? EMIT : ISSUE;
      end
      EMIT: if (out_ready) begin
        state_d = last_px ? DONE : ISSUE;
        col_d = last_px ? col_q : last_col ? '0 : col_q + 1'b1;
        row_d = !last_px && last_col ? row_q + 1'b1 : row_q;
        ch_d = last_px ? ch_q : '0;
        acc_d = last_px ? acc_q : bias;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      ch_q <= '0;
      acc_q <= '0;
      relu_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      ch_q <= ch_d;
      acc_q <= acc_d;
      relu_q <= relu_d;
    end
  end
  assign out_valid = state_q == EMIT;
  assign out_data = out_valid && !(relu_q && acc_q[ACC_W-1]) ? acc_q : '0;
  assign out_row = row_q;
  assign out_col = col_q;
  assign busy = state_q == ISSUE || state_q == WAIT || state_q == EMIT;
  assign done = state_q == DONE;
endmodule
